sd_frame_write_scheduler: RTL and testbench

SD_FRAME_WRITE_SCHEDULER -- requirements
Module: sd_frame_write_scheduler

---
 rtl/sd_frame_write_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_sd_frame_write_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_frame_write_scheduler.sv
// Camera-to-SD block write scheduler: buffers captured pixel words in a show-ahead
// FIFO and sequences one SD block write per WORDS_PER_BLOCK words until a frame is done.
module sd_frame_write_scheduler #(
    parameter int WORDS_PER_BLOCK  = 512,
    parameter int BLOCKS_PER_FRAME = 300,
    parameter int FIFO_AW          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        sd_idle,
    input  logic        sd_rd_fifo,
    output logic        sd_write,
    output logic [15:0] sd_data,
    output logic        frame_done,
    output logic        busy,
    output logic        overflow,
    output logic        underrun,
    output logic        timeout,
    output logic [15:0] block_cnt
);

    localparam int                 DEPTH       = 1 << FIFO_AW;
    localparam logic [31:0]        WPB_C       = 32'(WORDS_PER_BLOCK);
    localparam logic [31:0]        BPF_C       = 32'(BLOCKS_PER_FRAME);
    localparam logic [31:0]        FRAME_WORDS = 32'(WORDS_PER_BLOCK * BLOCKS_PER_FRAME);
    localparam logic [FIFO_AW:0]   FULL_COUNT  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   ZERO_COUNT  = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]   CNT_ONE     = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ZERO    = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE     = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [7:0]         WAIT_LAST   = 8'd254;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        FILL     = 3'd2,
        ISSUE    = 3'd3,
        WAIT_ACK = 3'd4,
        STREAM   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t             state_r, next_s;
    logic [15:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [31:0]        cap_cnt_r;
    logic               cap_active_r;
    logic [7:0]         wait_cnt_r;
    logic [15:0]        block_cnt_r;
    logic               sd_write_r, frame_done_r, busy_r;
    logic               overflow_r, underrun_r, timeout_r;

    logic full_s, empty_s, start_s, push_req_s, push_s, pop_s;
    logic ovf_s, udr_s, tmo_s, block_ready_s, last_block_s, block_end_s;
    logic [15:0] block_inc_s;

    assign full_s        = (count_r == FULL_COUNT);
    assign empty_s       = (count_r == ZERO_COUNT);
    assign start_s       = (state_r == ARM) && frame_start;
    assign push_req_s    = pix_valid && cap_active_r && !start_s;
    assign pop_s         = sd_rd_fifo && !empty_s && !start_s;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
    assign push_s        = push_req_s && (!full_s || pop_s);
    assign ovf_s         = push_req_s && full_s && !pop_s;
    assign udr_s         = sd_rd_fifo && empty_s;
    assign tmo_s         = (state_r == WAIT_ACK) && sd_idle && (wait_cnt_r == WAIT_LAST);
    assign block_ready_s = (32'(count_r) >= WPB_C);
    assign last_block_s  = (({16'd0, block_cnt_r} + 32'd1) == BPF_C);
    assign block_end_s   = (state_r == STREAM) && sd_idle;
    assign block_inc_s   = (block_cnt_r == 16'hFFFF) ? block_cnt_r : (block_cnt_r + 16'd1);

    assign sd_data    = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
    assign sd_write   = sd_write_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign underrun   = underrun_r;
    assign timeout    = timeout_r;
    assign block_cnt  = block_cnt_r;

    // Next-state logic of the block write sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:     if (enable) next_s = ARM; else next_s = IDLE;
            ARM: begin
                if (start_s)      next_s = FILL;
                else if (!enable) next_s = IDLE;
                else              next_s = ARM;
            end
            FILL: begin
                if (block_ready_s && sd_idle)              next_s = ISSUE;
                else if (!enable && block_cnt_r == 16'd0)  next_s = IDLE;
                else                                       next_s = FILL;
            end
            ISSUE:    next_s = WAIT_ACK;
            WAIT_ACK: begin
                if (!sd_idle)   next_s = STREAM;
                else if (tmo_s) next_s = ISSUE;
                else            next_s = WAIT_ACK;
            end
            STREAM: begin
                if (!sd_idle)          next_s = STREAM;
                else if (last_block_s) next_s = DONE;
                else if (enable)       next_s = FILL;
                else                   next_s = IDLE;
            end
            DONE:     if (enable) next_s = ARM; else next_s = IDLE;
            default:  next_s = IDLE;
        endcase
    end

    // State register, registered control outputs and block/wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sd_write_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            wait_cnt_r   <= 8'd0;
            block_cnt_r  <= 16'd0;
        end else begin
            state_r      <= next_s;
            sd_write_r   <= (state_r == ISSUE);
            frame_done_r <= (next_s == DONE);
            busy_r       <= (next_s != IDLE) && (next_s != ARM);
            wait_cnt_r   <= (state_r == WAIT_ACK) ? (wait_cnt_r + 8'd1) : 8'd0;
            if (start_s)          block_cnt_r <= 16'd0;
            else if (block_end_s) block_cnt_r <= block_inc_s;
            else                  block_cnt_r <= block_cnt_r;
        end
    end

    // FIFO pointers, occupancy and capture window tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= ZERO_COUNT;
            cap_cnt_r    <= 32'd0;
            cap_active_r <= 1'b0;
        end else if (start_s) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= ZERO_COUNT;
            cap_cnt_r    <= 32'd0;
            cap_active_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE; else wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE; else rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (push_s) begin
                cap_cnt_r <= cap_cnt_r + 32'd1;
                if (cap_cnt_r + 32'd1 == FRAME_WORDS) cap_active_r <= 1'b0;
                else                                  cap_active_r <= cap_active_r;
            end else begin
                cap_cnt_r    <= cap_cnt_r;
                cap_active_r <= cap_active_r;
            end
        end
    end

    // Sticky error flags, cleared only when a new frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else if (start_s) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            overflow_r <= overflow_r | ovf_s;
            underrun_r <= underrun_r | udr_s;
            timeout_r  <= timeout_r | tmo_s;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= pix_data;
    end

endmodule

// File: tb/tb_sd_frame_write_scheduler.sv
// Directed bench for sd_frame_write_scheduler with a small configuration
// (16-word blocks, 2 blocks per frame, 16-word FIFO).
module tb_sd_frame_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, enable, frame_start, pix_valid, sd_idle, sd_rd_fifo;
    logic [15:0] pix_data;
    logic        sd_write, frame_done, busy, overflow, underrun, timeout;
    logic [15:0] sd_data, block_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sd_frame_write_scheduler #(
        .WORDS_PER_BLOCK (16),
        .BLOCKS_PER_FRAME(2),
        .FIFO_AW         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .sd_idle    (sd_idle),
        .sd_rd_fifo (sd_rd_fifo),
        .sd_write   (sd_write),
        .sd_data    (sd_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow),
        .underrun   (underrun),
        .timeout    (timeout),
        .block_cnt  (block_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [15:0] base, input int n);
        pix_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_data = base + 16'(i);
            step();
        end
        pix_valid = 1'b0;
    endtask

    // Issue one block from FILL (FIFO holding 16 words, sd_idle low) and stream it out.
    task automatic run_block(input logic [15:0] base);
        sd_idle = 1'b1;
        step();
        check("issue_entered_no_write", sd_write, 32'd0);
        step();
        check("sd_write_pulse", sd_write, 32'd1);
        sd_idle = 1'b0;
        step();
        check("sd_write_single", sd_write, 32'd0);
        check("stream_busy", busy, 32'd1);
        sd_rd_fifo = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("stream_data", sd_data, 32'(base + 16'(i)));
            step();
        end
        sd_rd_fifo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  gap;
        bit  found;
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        pix_data = 16'h0000; sd_idle = 1'b0; sd_rd_fifo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_sd_write", sd_write, 32'd0);
        check("rst_sd_data", sd_data, 32'd0);
        check("rst_frame_done", frame_done, 32'd0);
        check("rst_flags", {overflow, underrun, timeout}, 32'd0);
        check("rst_block_cnt", block_cnt, 32'd0);

        // Full frame of two blocks
        rst_n = 1'b1; enable = 1'b1;
        step();
        check("arm_not_busy", busy, 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("fill_busy", busy, 32'd1);
        pix_valid = 1'b1; pix_data = 16'hA000;
        step();
        pix_valid = 1'b0;
        check("push_latency", sd_data, 32'h0000A000);
        push_n(16'hA001, 15);
        check("first_word_head", sd_data, 32'h0000A000);
        run_block(16'hA000);
        sd_idle = 1'b1;
        step();
        sd_idle = 1'b0;
        check("block1_cnt", block_cnt, 32'd1);
        check("block1_fill_busy", busy, 32'd1);
        push_n(16'hB000, 16);
        push_n(16'hBEEF, 1);
        check("outside_window_no_ovf", overflow, 32'd0);
        check("outside_window_count", 32'(dut.count_r), 32'd16);
        run_block(16'hB000);
        check("frame_done_before", frame_done, 32'd0);
        sd_idle = 1'b1;
        step();
        sd_idle = 1'b0;
        check("block2_cnt", block_cnt, 32'd2);
        check("frame_done_pulse", frame_done, 32'd1);
        step();
        check("frame_done_single", frame_done, 32'd0);
        check("back_to_arm", busy, 32'd0);

        // Overflow and simultaneous push/pop while full
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("start_clears_block_cnt", block_cnt, 32'd0);
        push_n(16'hC000, 17);
        check("overflow_set", overflow, 32'd1);
        check("full_count", 32'(dut.count_r), 32'd16);
        pix_valid = 1'b1; pix_data = 16'hC011; sd_rd_fifo = 1'b1;
        step();
        pix_valid = 1'b0; sd_rd_fifo = 1'b0;
        check("push_pop_full_count", 32'(dut.count_r), 32'd16);
        check("push_pop_full_head", sd_data, 32'h0000C001);

        // Underrun on empty FIFO
        sd_rd_fifo = 1'b1;
        repeat (16) step();
        check("drained_count", 32'(dut.count_r), 32'd0);
        check("no_underrun_yet", underrun, 32'd0);
        step();
        sd_rd_fifo = 1'b0;
        check("underrun_set", underrun, 32'd1);
        check("underrun_data_zero", sd_data, 32'd0);

        // Leave FILL with no block done, re-arm: flags clear on new frame
        enable = 1'b0;
        step();
        check("fill_exit_idle", busy, 32'd0);
        enable = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("flags_cleared", {overflow, underrun, timeout}, 32'd0);

        // WAIT_ACK timeout and retry
        push_n(16'hD000, 16);
        sd_idle = 1'b1;
        step();
        step();
        check("tmo_first_write", sd_write, 32'd1);
        check("tmo_not_yet", timeout, 32'd0);
        gap = 0; found = 1'b0;
        while (!found && gap < 300) begin
            step();
            gap++;
            if (sd_write) found = 1'b1;
        end
        check("tmo_second_write_seen", 32'(found), 32'd1);
        check("tmo_retry_gap", 32'(gap), 32'd256);
        check("timeout_set", timeout, 32'd1);

        // enable dropped during STREAM: block still completes, then IDLE
        sd_idle = 1'b0;
        step();
        enable = 1'b0;
        step();
        check("stream_not_aborted", busy, 32'd1);
        sd_idle = 1'b1;
        step();
        sd_idle = 1'b0;
        check("stream_done_cnt", block_cnt, 32'd1);
        check("stream_done_idle", busy, 32'd0);

        // Reset asserted in the middle of a STREAM
        enable = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        push_n(16'hE000, 16);
        run_block(16'hE000);
        sd_idle = 1'b1;
        step();
        sd_idle = 1'b0;
        push_n(16'hE100, 16);
        sd_idle = 1'b1;
        step();
        step();
        sd_idle = 1'b0;
        step();
        sd_rd_fifo = 1'b1;
        repeat (17) step();
        sd_rd_fifo = 1'b0;
        check("mid_stream_underrun", underrun, 32'd1);
        check("mid_stream_busy", busy, 32'd1);
        check("mid_stream_cnt", block_cnt, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 32'd0);
        check("async_rst_block_cnt", block_cnt, 32'd0);
        check("async_rst_flags", {overflow, underrun, timeout}, 32'd0);
        check("async_rst_outputs", {sd_write, frame_done, sd_data}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_arm", busy, 32'd0);
        check("post_rst_cnt", block_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
